// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared architecture constants for the data-memory arbiter: address/data
// widths, FSM state encodings, the wait-counter width and a helper that
// computes the wait-counter preload for a given read latency.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 10
`endif

`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

`ifndef ARB_STATE_IDLE
`define ARB_STATE_IDLE  2'b00
`define ARB_STATE_ISSUE 2'b01
`define ARB_STATE_WAIT  2'b10
`define ARB_STATE_RESP  2'b11
`endif

package memory_arbiter_pkg;

    localparam int ADDR_W = `ADDRESS_SIZE;
    localparam int DATA_W = `DATA_SIZE;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = `ARB_STATE_IDLE,
        ISSUE = `ARB_STATE_ISSUE,
        WAIT  = `ARB_STATE_WAIT,
        RESP  = `ARB_STATE_RESP
    } arb_state_e;

    // WAIT covers latency-1 cycles; the counter is checked for zero before
    // decrementing, so it is preloaded with latency-2.
    function automatic logic [CNT_W-1:0] waitLoad(input int latency);
        if (latency <= 2) begin
            return '0;
        end
        return CNT_W'(latency - 2);
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_select2.sv
// -----------------------------------------------------------------------------
// rr_select2
// Two-way round-robin selector used by memory_arbiter.
// Ports:
//   req0, req1 : requests from port 0 / port 1
//   last       : port served most recently (0 or 1)
//   winner     : selected port (only meaningful when a request is present)
// -----------------------------------------------------------------------------
module rr_select2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // A lone requester always wins; on a tie the port not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Arbitrates a single data memory between port 0 (core) and port 1
// (auxiliary loader). One access is outstanding at a time; ties are resolved
// round-robin. Reads return data READ_LATENCY cycles after the mem_read strobe.
// Ports:
//   clock, reset                : clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN     : request, write enable, address, write data
//   gntN                        : one-cycle accept pulse (issue cycle)
//   rvalidN, rdataN             : one-cycle read-valid pulse, held read data
//   mem_read, mem_write         : memory strobes
//   mem_address, mem_data_out   : memory address / write data
//   mem_data_in                 : memory read data
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    arb_state_e        state_q,      state_d;
    logic              winnerId_q,   winnerId_d;
    logic              isWrite_q,    isWrite_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              lastServed_q, lastServed_d;
    logic [CNT_W-1:0]  waitCnt_q,    waitCnt_d;
    logic              rvalid0_q,    rvalid0_d;
    logic              rvalid1_q,    rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;

    logic              winner;

    rr_select2 u_rrSelect (
        .req0   (req0),
        .req1   (req1),
        .last   (lastServed_q),
        .winner (winner)
    );

    // State and datapath registers. The last-served pointer resets to port 1
    // so that port 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            winnerId_q   <= 1'b0;
            isWrite_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lastServed_q <= 1'b1;
            waitCnt_q    <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            winnerId_q   <= winnerId_d;
            isWrite_q    <= isWrite_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lastServed_q <= lastServed_d;
            waitCnt_q    <= waitCnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Next-state and output logic. Memory-side outputs and grants are decoded
    // from the registered state, so reset clears them immediately. rvalid is
    // registered in RESP so that it coincides with the next IDLE cycle.
    always_comb begin
        state_d      = state_q;
        winnerId_d   = winnerId_q;
        isWrite_d    = isWrite_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lastServed_d = lastServed_q;
        waitCnt_d    = waitCnt_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        gnt0         = 1'b0;
        gnt1         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_data_out = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winnerId_d   = winner;
                    isWrite_d    = winner ? we1    : we0;
                    addr_d       = winner ? addr1  : addr0;
                    wdata_d      = winner ? wdata1 : wdata0;
                    lastServed_d = winner;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                gnt0        = ~winnerId_q;
                gnt1        = winnerId_q;
                mem_address = addr_q;
                if (isWrite_q) begin
                    mem_write    = 1'b1;
                    mem_data_out = wdata_q;
                    state_d      = IDLE;
                end else begin
                    mem_read = 1'b1;
                    if (READ_LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        waitCnt_d = waitLoad(READ_LATENCY);
                        state_d   = WAIT;
                    end
                end
            end

            WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end

            RESP: begin
                if (winnerId_q) begin
                    rdata1_d  = mem_data_in;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_data_in;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 READ_LATENCY, 1, cycles from the mem_read strobe until mem_data_in is valid; legal range 1..7.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  access request from port 0 (core) / port 1 (auxiliary loader).
REQ-005 we0 / we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-006 addr0 / addr1  input  `ADDRESS_SIZE each  data memory address.
REQ-007 wdata0 / wdata1  input  `DATA_SIZE each  write data.
REQ-008 gnt0 / gnt1  output  1 each  one-cycle pulse: the request has been accepted and is being issued to memory.
REQ-009 rvalid0 / rvalid1  output  1 each  one-cycle pulse: rdataN holds read data.
REQ-010 rdata0 / rdata1  output  `DATA_SIZE each  read data, held until the next read completes on that port.
REQ-011 mem_read / mem_write  output  1 each  memory strobes, active 1.
REQ-012 mem_address  output  `ADDRESS_SIZE  memory address.
REQ-013 mem_data_out  output  `DATA_SIZE  data to memory.
REQ-014 mem_data_in  input  `DATA_SIZE  data from memory.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP; encoded in 2 bits.
REQ-016 IDLE: with no request, stay in IDLE; with any reqN high, select a winner, latch its id, we, addr and wdata, and go to ISSUE on the next edge.
REQ-017 Arbitration: when only one port requests, that port wins; when both request, the port not served last wins; the last-served pointer updates on every IDLE->ISSUE transition.
REQ-018 ISSUE lasts exactly one cycle: gntN=1 for the winner; mem_write=1 with the latched address/data if we, else mem_read=1 with the latched address.
REQ-019 ISSUE exit: a write goes to IDLE; a read goes to WAIT.
REQ-020 WAIT holds for READ_LATENCY-1 further cycles, counted by a 3-bit down-counter, then goes to RESP.
REQ-021 RESP is the cycle READ_LATENCY after ISSUE: latch mem_data_in into rdataN of the winner, then go to IDLE.
REQ-022 rvalidN=1 for exactly the cycle after RESP, while the FSM is back in IDLE, so arbitration can overlap it.
REQ-023 When READ_LATENCY=1, WAIT is skipped (ISSUE -> RESP).
REQ-024 Outside ISSUE: mem_read=mem_write=0, mem_address=0, mem_data_out=0.
REQ-025 Requester rules:
- reqN and its qualifiers stay stable until gntN.
- A requester may deassert reqN in the gnt cycle or raise a new request immediately.
- A reqN dropped before gnt is simply not served; there is no error.
REQ-026 Latency: a write takes 2 cycles from IDLE sample to gnt completion; a read delivers rvalid READ_LATENCY+2 cycles after the IDLE sample.
REQ-027 At most one access is outstanding; no request is sampled outside IDLE.
REQ-028 Requests arriving while busy wait; fairness guarantees that each port waits at most one other access.

Reset
REQ-029 When reset is asserted:
- FSM goes to IDLE immediately; counter = 0; last-served pointer = port 1, so port 0 wins the first tie.
- All gnt, rvalid and mem strobes = 0; mem_address, mem_data_out, rdata0 and rdata1 = 0.
REQ-030 Reset mid-operation discards the in-flight access: no gnt or rvalid is produced after release, and the FSM restarts from IDLE.

Structure
REQ-031 `ADDRESS_SIZE and `DATA_SIZE come from the shared architecture header; the FSM state encodings are added to that header as named constants.
REQ-032 The block is a single module; the round-robin selector is natural as sub-module rr_select2 (inputs req0, req1, last; output winner).

Verification
REQ-033 Single port-0 write (addr 0x010, data 0x1234), then read 0x010 with READ_LATENCY=1:
- Write: gnt0 on cycle 2, with mem_write=1 and mem_address=0x010 in the same cycle.
- Read: rvalid0 on cycle 3 after the read sample, with rdata0=0x1234.
REQ-034 Both ports request reads continuously from reset -> grants alternate 0,1,0,1 and never repeat the same port twice.
REQ-035 READ_LATENCY=3, port-1 read of 0x3FF whose memory model returns 0xBEEF -> mem_read high exactly one cycle, rvalid1 five cycles after the sample, rdata1=0xBEEF, rvalid0 stays 0.
REQ-036 Reset asserted during WAIT of a port-0 read -> all outputs 0 at once and no rvalid0 after release; a new port-1 request after release is granted normally.
REQ-037 Port-0 write in flight while port 1 raises req1 -> gnt1 is issued 2 cycles after the gnt0 cycle; the memory strobes are never high in two consecutive cycles.
